mem_port_arbiter: RTL and testbench

Shares the single 32-bit memory read port and byte write path between the front-end instruction fetch and the execute-stage load/store path. Data accesses have priority, with a starvation counter that guarantees forward progress for fetch. Each requester sees a simple request/acknowledge handshake. The fetch side's acknowledge drives the front end's memory-ready input directly.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Optional bus watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        f_req,
    input  logic [15:0] f_pc,
    output logic [31:0] f_opcode,
    output logic        f_rdy,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [7:0]  d_wdata,
    output logic [7:0]  d_rdata,
    output logic        d_ack,
    output logic        m_en,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, F_BUSY, D_BUSY} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       pick_f;
    logic       pick_d;
    logic       grant_f;
    logic       grant_d;
    logic       contested;
    logic [7:0] rd_byte;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wd;
`else
    assign bus_err = 1'b0;
`endif

    // Arbitration; an acked side cannot win in its ack cycle, and if it
    // would have won the slot waits a cycle instead of going to the loser.
    always_comb begin
        pick_f    = f_req & (~d_req | (starve_cnt == SMAX));
        pick_d    = d_req & ~pick_f;
        grant_f   = pick_f & ~f_rdy;
        grant_d   = pick_d & ~d_ack;
        contested = f_req & ~f_rdy;
    end

    // Byte lane of the read word addressed by the latched data address.
    always_comb begin
        rd_byte = m_rdata[7:0];
        case (m_addr[1:0])
            2'b00:   rd_byte = m_rdata[7:0];
            2'b01:   rd_byte = m_rdata[15:8];
            2'b10:   rd_byte = m_rdata[23:16];
            default: rd_byte = m_rdata[31:24];
        endcase
    end

    // Grant FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            f_rdy      <= 1'b0;
            d_ack      <= 1'b0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= 16'd0;
            m_wdata    <= 8'd0;
            f_opcode   <= 32'd0;
            d_rdata    <= 8'd0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err    <= 1'b0;
            wd         <= 8'd0;
`endif
        end else begin
            f_rdy <= 1'b0;
            d_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_f) begin
                        state      <= F_BUSY;
                        m_en       <= 1'b1;
                        m_addr     <= f_pc;
                        m_we       <= 1'b0;
                        m_wdata    <= 8'd0;
                        starve_cnt <= 4'd0;
`ifdef MEM_ARB_TIMEOUT_EN
                        wd         <= 8'd0;
`endif
                    end else if (grant_d) begin
                        state   <= D_BUSY;
                        m_en    <= 1'b1;
                        m_addr  <= d_addr;
                        m_we    <= d_we;
                        m_wdata <= d_wdata;
                        if (contested && starve_cnt != SMAX)
                            starve_cnt <= starve_cnt + 4'd1;
`ifdef MEM_ARB_TIMEOUT_EN
                        wd      <= 8'd0;
`endif
                    end
                end
                F_BUSY: begin
                    if (m_ack) begin
                        f_opcode <= m_rdata;
                        f_rdy    <= 1'b1;
                        m_en     <= 1'b0;
                        state    <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (wd == 8'd254) begin
                        f_opcode <= 32'hFFFF_FFFF;
                        f_rdy    <= 1'b1;
                        bus_err  <= 1'b1;
                        m_en     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wd <= wd + 8'd1;
`endif
                    end
                end
                D_BUSY: begin
                    if (m_ack) begin
                        d_rdata <= m_we ? 8'd0 : rd_byte;
                        d_ack   <= 1'b1;
                        m_en    <= 1'b0;
                        state   <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (wd == 8'd254) begin
                        d_rdata <= 8'hFF;
                        d_ack   <= 1'b1;
                        bus_err <= 1'b1;
                        m_en    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wd <= wd + 8'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    m_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors plus multi-cycle corner sequences.
// Timeout checks follow MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        f_req;
    logic [15:0] f_pc;
    logic [31:0] f_opcode;
    logic        f_rdy;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic [7:0]  d_rdata;
    logic        d_ack;
    logic        m_en;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_err;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .a_rst(a_rst),
        .f_req(f_req), .f_pc(f_pc), .f_opcode(f_opcode), .f_rdy(f_rdy),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [31:0] rdata;
        int          lat;
        logic        exp_we;
        logic [7:0]  exp_wd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vec[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [5:0] gfv;
        int         gap[6];
        int         ng;
        int         idle;
        int         n;
        logic       prev;
        logic       bad;
        logic [3:0] s4;
        logic [3:0] s5;

        // is_d we addr wdata rdata lat exp_we exp_wd exp_data
        vec[0] = '{1'b0, 1'b1, 16'h1234, 8'h77, 32'hA9EA0042, 0,
                   1'b0, 8'h00, 32'hA9EA0042};
        vec[1] = '{1'b1, 1'b0, 16'h0203, 8'h00, 32'h11223344, 0,
                   1'b0, 8'h00, 32'h00000011};
        vec[2] = '{1'b1, 1'b0, 16'h0200, 8'h00, 32'h11223344, 1,
                   1'b0, 8'h00, 32'h00000044};
        vec[3] = '{1'b1, 1'b0, 16'h0201, 8'h00, 32'h11223344, 0,
                   1'b0, 8'h00, 32'h00000033};
        vec[4] = '{1'b1, 1'b0, 16'h0202, 8'h00, 32'h11223344, 2,
                   1'b0, 8'h00, 32'h00000022};
        vec[5] = '{1'b1, 1'b1, 16'h0010, 8'h5A, 32'hDEADBEEF, 0,
                   1'b1, 8'h5A, 32'h00000000};
        vec[6] = '{1'b0, 1'b0, 16'hFFFE, 8'h00, 32'h00000013, 3,
                   1'b0, 8'h00, 32'h00000013};

        a_rst = 1'b1;
        f_req = 1'b0; f_pc = 16'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'd0; d_wdata = 8'd0;
        m_rdata = 32'd0; m_ack = 1'b0;
        tick();
        tick();
        chk("rst_flags", 32'({f_rdy, d_ack, m_en, m_we, bus_err}), 32'd0);
        chk("rst_addr", 32'(m_addr), 32'd0);
        chk("rst_rdata", 32'({f_opcode, d_rdata} != 40'd0), 32'd0);
        a_rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            f_req   = ~vec[i].is_d;
            f_pc    = vec[i].addr;
            d_req   = vec[i].is_d;
            d_we    = vec[i].we;
            d_addr  = vec[i].addr;
            d_wdata = vec[i].wdata;
            tick();
            chk($sformatf("v%0d_men", i), 32'(m_en), 32'd1);
            chk($sformatf("v%0d_maddr", i), 32'(m_addr), 32'(vec[i].addr));
            chk($sformatf("v%0d_mwe", i), 32'(m_we), 32'(vec[i].exp_we));
            chk($sformatf("v%0d_mwd", i), 32'(m_wdata), 32'(vec[i].exp_wd));
            for (int k = 0; k < vec[i].lat; k++) begin
                tick();
                chk($sformatf("v%0d_stall", i),
                    32'({m_en, f_rdy, d_ack}), 32'd4);
            end
            m_ack = 1'b1;
            m_rdata = vec[i].rdata;
            tick();
            m_ack = 1'b0;
            f_req = 1'b0;
            d_req = 1'b0;
            chk($sformatf("v%0d_ack", i), 32'({m_en, f_rdy, d_ack}),
                vec[i].is_d ? 32'd1 : 32'd2);
            if (vec[i].is_d)
                chk($sformatf("v%0d_drd", i), 32'(d_rdata), vec[i].exp_data);
            else
                chk($sformatf("v%0d_fop", i), f_opcode, vec[i].exp_data);
            tick();
            chk($sformatf("v%0d_pulse", i), 32'({m_en, f_rdy, d_ack}), 32'd0);
        end

        m_ack = 1'b1;
        tick();
        tick();
        m_ack = 1'b0;
        chk("idle_ack", 32'({m_en, f_rdy, d_ack}), 32'd0);

        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0001;
        tick();
        d_req = 1'b0;
        tick();
        chk("drop_busy", 32'({m_en, d_ack}), 32'd2);
        m_ack = 1'b1; m_rdata = 32'hAABBCCDD;
        tick();
        m_ack = 1'b0;
        chk("drop_ack", 32'({m_en, d_ack}), 32'd1);
        chk("drop_rd", 32'(d_rdata), 32'h000000CC);
        tick();

        f_pc = 16'h1000; d_addr = 16'h2000; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        gfv = 6'd0; ng = 0; idle = 0; prev = 1'b0;
        s4 = 4'hF; s5 = 4'hF;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            tick();
            if (m_en && !prev) begin
                gfv[ng] = (m_addr == 16'h1000);
                gap[ng] = idle;
                if (ng == 3) s4 = dut.starve_cnt;
                if (ng == 4) s5 = dut.starve_cnt;
                ng++;
            end
            idle = m_en ? 0 : idle + 1;
            prev = m_en;
            m_ack = m_en;
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("starve_ngrants", 32'(ng), 32'd6);
        chk("starve_order", 32'(gfv), 32'h10);
        chk("starve_cnt_max", 32'(s4), 32'd4);
        chk("starve_cnt_clr", 32'(s5), 32'd0);
        chk("starve_gap_dd", 32'(gap[1]), 32'd2);
        chk("starve_gap_df", 32'(gap[4]), 32'd1);
        tick();
        m_ack = 1'b0;
        tick();
        tick();

        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 8'h5A;
        tick();
        chk("abort_wr", 32'({m_en, m_we, m_wdata}), 32'h35A);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0; d_req = 1'b0;
        chk("abort_flags", 32'({f_rdy, d_ack, m_en, m_we, bus_err}), 32'd0);
        chk("abort_bus", 32'({m_addr, m_wdata}), 32'd0);
        chk("abort_rdata", 32'({f_opcode, d_rdata} != 40'd0), 32'd0);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("abort_noack1", 32'({m_en, f_rdy, d_ack}), 32'd0);
        tick();
        chk("abort_noack2", 32'({m_en, f_rdy, d_ack}), 32'd0);

        f_req = 1'b1; f_pc = 16'h0040;
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        n = 0;
        while (m_en === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        f_req = 1'b0;
        chk("to_busy_cycles", 32'(n), 32'd255);
        chk("to_pulse", 32'({m_en, f_rdy, bus_err}), 32'd3);
        chk("to_opcode", f_opcode, 32'hFFFFFFFF);
        tick();
        chk("to_after", 32'({m_en, f_rdy, bus_err}), 32'd0);
`else
        bad = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (m_en !== 1'b1 || bus_err !== 1'b0 || f_rdy !== 1'b0)
                bad = 1'b1;
            tick();
        end
        f_req = 1'b0;
        chk("no_timeout", 32'(bad), 32'd0);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("no_timeout_rst", 32'({m_en, bus_err}), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
